// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width and the divider state encoding.
package mips_pkg;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// Start/result handshake between the control unit (master) and the divider (slave).
interface div_unit_if #(parameter int WIDTH = mips_pkg::WORD_W);
   logic             DIV_on;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic [WIDTH-1:0] Hi_out;
   logic [WIDTH-1:0] Lo_out;
   logic             div_busy;
   logic             div_done;
   logic             div_zero;

   modport master (
      output DIV_on, A_in, B_in,
      input  Hi_out, Lo_out, div_busy, div_done, div_zero
   );

   modport slave (
      input  DIV_on, A_in, B_in,
      output Hi_out, Lo_out, div_busy, div_done, div_zero
   );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: 32 iterations on magnitudes, then one
// sign-fix cycle. Quotient goes to Lo_out, remainder to Hi_out.
module div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic       clk,
   input  logic       reset,
   div_unit_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             sa;
   logic             sb;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] quo;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;
   logic             start;
   logic             b_zero;

   assign b_zero = (bus.B_in == '0);
   assign start  = (state == IDLE) && bus.DIV_on && !b_zero;
   assign rem_sh = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, mag_b};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         bus.div_busy <= 1'b0;
         bus.div_done <= 1'b0;
         bus.div_zero <= 1'b0;
      end else begin
         bus.div_done <= 1'b0;
         bus.div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.DIV_on) begin
                  if (b_zero) begin
                     bus.div_zero <= 1'b1;
                     bus.div_done <= 1'b1;
                  end else begin
                     state        <= RUN;
                     cnt          <= '0;
                     bus.div_busy <= 1'b1;
                  end
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               state        <= IDLE;
               bus.div_busy <= 1'b0;
               bus.div_done <= 1'b1;
            end
            default: begin
               state        <= IDLE;
               cnt          <= '0;
               bus.div_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sa         <= 1'b0;
         sb         <= 1'b0;
         mag_b      <= '0;
         quo        <= '0;
         rem        <= '0;
         bus.Hi_out <= '0;
         bus.Lo_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= bus.A_in[WIDTH-1];
                  sb    <= bus.B_in[WIDTH-1];
                  mag_b <= bus.B_in[WIDTH-1] ? -bus.B_in : bus.B_in;
                  quo   <= bus.A_in[WIDTH-1] ? -bus.A_in : bus.A_in;
                  rem   <= '0;
               end
            end
            RUN: begin
               // A clear sign bit on the trial means the divisor fits: keep it.
               rem <= trial[WIDTH] ? rem_sh : trial;
               quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            end
            FIX: begin
               bus.Lo_out <= (sa ^ sb) ? -quo : quo;
               bus.Hi_out <= sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed 32-bit divider for the MIPS datapath. It is the responder to the control unit's `DIV_on` request. It takes the dividend and divisor from the `div_srcA`/`div_srcB` operand muxes and produces quotient (`Lo_out`) and remainder (`Hi_out`) for the Hi/Lo registers. It reports completion and divide-by-zero back to the control unit, which uses them for state sequencing and the divide-by-zero exception.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported by the datapath.
- `clk`, input, 1: system clock. Rising edge active.
- `reset`, input, 1: one clock; reset is synchronous and active-high.
- `DIV_on`, input, 1: start request. Sampled only in IDLE.
- `A_in`, input, WIDTH: dividend, two's complement.
- `B_in`, input, WIDTH: divisor, two's complement.
- `Hi_out`, output, WIDTH: remainder. Registered; holds its value until the next successful divide.
- `Lo_out`, output, WIDTH: quotient. Registered; holds its value until the next successful divide.
- `div_busy`, output, 1: high while in RUN or FIX.
- `div_done`, output, 1: one-cycle completion pulse, also asserted on divide-by-zero.
- `div_zero`, output, 1: one-cycle pulse, divisor was zero.

## Operation
- Reset values: every output is 0, state is IDLE, iteration counter is 0, internal registers are 0.
- States:
  - IDLE → RUN on `DIV_on`=1 with `B_in`≠0.
  - IDLE → IDLE on `DIV_on`=1 with `B_in`=0: pulse `div_zero` and `div_done`; `Hi_out`/`Lo_out` are unchanged.
  - RUN → FIX after 32 iterations.
  - FIX → IDLE.
- Capture on start:
  - Capture the sign flags `sa` = `A_in[31]` and `sb` = `B_in[31]`.
  - Capture the magnitudes |A| and |B| as 32-bit unsigned values. |0x80000000| = 0x80000000 unsigned.
  - Clear the 33-bit partial remainder; load the quotient shift register with |A|.
- RUN iteration, restoring division, one quotient bit per cycle, MSB first:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − |B| (33-bit).
  - If trial ≥ 0: rem ← trial, quo[0] ← 1. Otherwise quo[0] ← 0.
  - The counter counts 0..31 and wraps to 0 on the exit to FIX.
- FIX (sign correction):
  - `Lo_out` = (sa^sb) ? −quo : quo.
  - `Hi_out` = sa ? −rem[31:0] : rem[31:0].
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF gives `Lo_out`=0x80000000 and `Hi_out`=0. No flag is raised; the control unit does not trap on div overflow.
- `DIV_on` while busy (RUN/FIX) is ignored and not queued.
- `A_in`/`B_in` may change after the start edge; the unit uses only captured values.
- `reset` during RUN/FIX: the next edge forces IDLE with all outputs 0. No `div_done` is produced for the aborted operation.

## Timing
- Edge E0: IDLE samples `DIV_on`=1.
- Divide-by-zero: `div_zero`=`div_done`=1 during the cycle after E0 only; `div_busy` stays 0.
- Normal case:
  - `div_busy`=1 after E0.
  - Edges E1..E32 perform the iterations.
  - Edge E33 (FIX) writes `Hi_out`/`Lo_out`, asserts `div_done` for the following cycle, and returns to IDLE with `div_busy`=0.
  - Latency is 33 cycles from the start edge to valid results.
- A new `DIV_on` is accepted in the same cycle `div_done` is high, because the unit is already in IDLE. Back-to-back throughput is 1 divide per 34 cycles.
- `div_done` and `div_zero` are never high for two consecutive cycles from the same request.

## Structure
- Shared package (`mips_pkg`) holds:
  - `WORD_W` = 32;
  - the `div_state_t` encoding IDLE=2'd0, RUN=2'd1, FIX=2'd2. Code 3 is illegal and recovers to IDLE.
- A single module with no sub-module. Magnitude and negation are inline expressions, one 33-bit subtractor is shared across iterations, and there is one always block for state plus a datapath block.
- The companion multiplier (`mult_unit`, `MULT_on`) is a separate block with the same handshake and is out of scope here.

## Test plan
- 7 / 2: start, wait → `div_done` at cycle 34 after the start edge, `Lo_out`=3, `Hi_out`=1; `div_busy` is high for exactly 33 cycles.
- −7 / 2 (0xFFFFFFF9 / 2) → `Lo_out`=0xFFFFFFFD, `Hi_out`=0xFFFFFFFF. Also 7 / −2 → `Lo_out`=0xFFFFFFFD, `Hi_out`=1.
- 0x80000000 / 0xFFFFFFFF → `Lo_out`=0x80000000, `Hi_out`=0, and `div_zero`=0.
- Preload a divide with `Hi_out`=1, `Lo_out`=3, then 5 / 0 → `div_zero`=`div_done`=1 for exactly one cycle after the start edge; `Hi_out`/`Lo_out` stay 1/3; `div_busy` never rises.
- Start 100 / 7, then pulse `DIV_on` with 9 / 3 at iteration 5 → the second request is ignored; the result is `Lo_out`=14, `Hi_out`=2.
- Start 100 / 7, assert `reset` at cycle 10 → after the next edge all outputs are 0 and the state is IDLE; no `div_done` appears within 40 cycles. A fresh 9 / 3 afterwards gives `Lo_out`=3, `Hi_out`=0.
